// File: rtl/huffman_pkg.sv
// ---------------------------------------------------------------------------
// huffman_pkg : shared Huffman code table, sizes and lookup helper
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package huffman_pkg;

   localparam int MAX_CODE = 9;
   localparam int CHUNK    = 4;
   localparam int SYM_W    = 4;
   localparam int LEN_W    = 4;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_EMIT = 1'b1
   } state_t;

   typedef struct packed {
      logic [MAX_CODE-1:0] code;
      logic [LEN_W-1:0]    len;
   } code_entry_t;

   // Codes are stored left-aligned so the emitter always takes the top bits.
   function automatic code_entry_t code_lookup(input logic [SYM_W-1:0] sym);
      code_entry_t e;
      e = '{code: '0, len: '0};
      case (sym)
         4'h0: e = '{code: 9'b000000000, len: 4'd2};
         4'h1: e = '{code: 9'b010000000, len: 4'd3};
         4'hF: e = '{code: 9'b011000000, len: 4'd3};
         4'h2: e = '{code: 9'b100000000, len: 4'd4};
         4'hE: e = '{code: 9'b100100000, len: 4'd4};
         4'h3: e = '{code: 9'b101000000, len: 4'd4};
         4'hD: e = '{code: 9'b101100000, len: 4'd4};
         4'h4: e = '{code: 9'b110000000, len: 4'd5};
         4'hC: e = '{code: 9'b110010000, len: 4'd5};
         4'h5: e = '{code: 9'b110100000, len: 4'd5};
         4'hB: e = '{code: 9'b110110000, len: 4'd5};
         4'h6: e = '{code: 9'b111000000, len: 4'd6};
         4'hA: e = '{code: 9'b111001000, len: 4'd6};
         4'h7: e = '{code: 9'b111010000, len: 4'd6};
         4'h9: e = '{code: 9'b111011000, len: 4'd6};
         default: e = '{code: 9'b111100000, len: 4'd9};
      endcase
      return e;
   endfunction

endpackage

`default_nettype wire

// File: rtl/huffman_code_rom.sv
// ---------------------------------------------------------------------------
// huffman_code_rom : combinational symbol -> {left-aligned code, length}
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module huffman_code_rom
   import huffman_pkg::*;
(
   input  logic [SYM_W-1:0]    sym_i,
   output logic [MAX_CODE-1:0] code_o,
   output logic [LEN_W-1:0]    len_o
);

   code_entry_t entry;

   always_comb begin
      entry  = code_lookup(sym_i);
      code_o = entry.code;
      len_o  = entry.len;
   end

endmodule

`default_nettype wire

// File: rtl/huffman_chunk_encoder.sv
// ---------------------------------------------------------------------------
// huffman_chunk_encoder : emits Huffman codes MSB-first as (bits,len) chunks
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module huffman_chunk_encoder #(
   parameter int MAX_CODE = huffman_pkg::MAX_CODE,
   parameter int CHUNK    = huffman_pkg::CHUNK,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       symData,
   input  logic             sValid,
   output logic             sReady,
   output logic [CHUNK-1:0] out_bits,
   output logic [2:0]       out_len,
   output logic             mValid,
   input  logic             mReady,
   output logic             busy,
   output logic [CNT_W-1:0] bits_sent
);

   import huffman_pkg::*;

   localparam int ROM_W = huffman_pkg::MAX_CODE;

   state_t              state_q, state_d;
   logic [MAX_CODE-1:0] code_buf_q, code_buf_d;
   logic [3:0]          rem_len_q, rem_len_d;
   logic [CHUNK-1:0]    out_bits_q, out_bits_d;
   logic [2:0]          out_len_q, out_len_d;
   logic                mvalid_q, mvalid_d;
   logic [CNT_W-1:0]    bits_sent_q, bits_sent_d;

   logic [ROM_W-1:0]    rom_code;
   logic [3:0]          rom_len;
   logic [MAX_CODE-1:0] load_buf;
   logic                hs_out;
   logic                last_chunk;
   logic                accept;
   logic [CHUNK-1:0]    top_bits;
   logic [CHUNK-1:0]    len_mask;
   logic [CNT_W:0]      sum;

   huffman_code_rom u_rom (
      .sym_i  (symData),
      .code_o (rom_code),
      .len_o  (rom_len)
   );

   assign load_buf = MAX_CODE'(rom_code) << (MAX_CODE - ROM_W);

   always_comb begin
      hs_out     = mvalid_q && mReady;
      last_chunk = (rem_len_q <= 4'(CHUNK));
      sReady     = (state_q == ST_IDLE) || (hs_out && last_chunk);
      accept     = sValid && sReady;

      state_d    = state_q;
      code_buf_d = code_buf_q;
      rem_len_d  = rem_len_q;

      // A new code may replace the final chunk of the previous one in the same cycle.
      if (accept) begin
         code_buf_d = load_buf;
         rem_len_d  = rom_len;
         state_d    = ST_EMIT;
      end else if (hs_out) begin
         code_buf_d = code_buf_q << out_len_q;
         rem_len_d  = rem_len_q - 4'(out_len_q);
         state_d    = last_chunk ? ST_IDLE : ST_EMIT;
      end

      if (state_d == ST_EMIT) begin
         out_len_d = (rem_len_d > 4'(CHUNK)) ? 3'(CHUNK) : rem_len_d[2:0];
      end else begin
         out_len_d = 3'd0;
      end
      top_bits   = code_buf_d[MAX_CODE-1 -: CHUNK];
      len_mask   = ~({CHUNK{1'b1}} >> out_len_d);
      out_bits_d = top_bits & len_mask;
      mvalid_d   = (state_d == ST_EMIT);

      sum = {1'b0, bits_sent_q} + (CNT_W+1)'(out_len_q);
      if (hs_out) begin
         bits_sent_d = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
      end else begin
         bits_sent_d = bits_sent_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         code_buf_q  <= '0;
         rem_len_q   <= '0;
         out_bits_q  <= '0;
         out_len_q   <= '0;
         mvalid_q    <= 1'b0;
         bits_sent_q <= '0;
      end else begin
         state_q     <= state_d;
         code_buf_q  <= code_buf_d;
         rem_len_q   <= rem_len_d;
         out_bits_q  <= out_bits_d;
         out_len_q   <= out_len_d;
         mvalid_q    <= mvalid_d;
         bits_sent_q <= bits_sent_d;
      end
   end

   assign out_bits  = out_bits_q;
   assign out_len   = out_len_q;
   assign mValid    = mvalid_q;
   assign busy      = (state_q == ST_EMIT);
   assign bits_sent = bits_sent_q;

endmodule

`default_nettype wire

// File: tb/tb_huffman_chunk_encoder.sv
// ---------------------------------------------------------------------------
// tb_huffman_chunk_encoder : directed + random bench with chunk-stream model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_huffman_chunk_encoder;

   localparam int CHUNK = 4;
   localparam int CNT_W = 8;

   logic             clk;
   logic             reset;
   logic [3:0]       symData;
   logic             sValid;
   logic             sReady;
   logic [CHUNK-1:0] out_bits;
   logic [2:0]       out_len;
   logic             mValid;
   logic             mReady;
   logic             busy;
   logic [CNT_W-1:0] bits_sent;

   huffman_chunk_encoder #(.MAX_CODE(9), .CHUNK(CHUNK), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .symData   (symData),
      .sValid    (sValid),
      .sReady    (sReady),
      .out_bits  (out_bits),
      .out_len   (out_len),
      .mValid    (mValid),
      .mReady    (mReady),
      .busy      (busy),
      .bits_sent (bits_sent)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] bits;
      logic [2:0] len;
      bit         last;
   } chunk_t;

   chunk_t q[$];
   int     sent[$];
   int     decoded[$];
   string  rx;
   int     bits_model;
   int     total;
   int     bad;
   bit     last_sready;

   function automatic string code_of(input int s);
      case (s)
         0:  return "00";
         1:  return "010";
         -1: return "011";
         2:  return "1000";
         -2: return "1001";
         3:  return "1010";
         -3: return "1011";
         4:  return "11000";
         -4: return "11001";
         5:  return "11010";
         -5: return "11011";
         6:  return "111000";
         -6: return "111001";
         7:  return "111010";
         -7: return "111011";
         default: return "111100000";
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_code(input int s);
      string c;
      int    n;
      chunk_t ch;
      c = code_of(s);
      for (int i = 0; i < c.len(); i += CHUNK) begin
         n = (c.len() - i < CHUNK) ? c.len() - i : CHUNK;
         ch.bits = '0;
         for (int j = 0; j < n; j++) begin
            if (c[i+j] == "1") ch.bits[CHUNK-1-j] = 1'b1;
         end
         ch.len  = 3'(n);
         ch.last = (i + CHUNK >= c.len());
         q.push_back(ch);
      end
   endtask

   task automatic decode_rx();
      bit found;
      string c;
      found = 1'b1;
      while (found) begin
         found = 1'b0;
         for (int s = -8; s <= 7; s++) begin
            c = code_of(s);
            if (!found && rx.len() >= c.len() && rx.substr(0, c.len()-1) == c) begin
               decoded.push_back(s);
               rx = (rx.len() > c.len()) ? rx.substr(c.len(), rx.len()-1) : "";
               found = 1'b1;
            end
         end
      end
   endtask

   // One clock cycle: drive, check against the model, then advance the model.
   task automatic cyc(input bit rst, input bit sv, input int sd, input bit mr, output bit acc);
      bit         exp_mv, exp_sr, hs_in, hs_out;
      logic [3:0] ob;
      logic [2:0] ol;
      reset = rst; sValid = sv; symData = 4'(sd); mReady = mr;
      #1;
      exp_mv = (q.size() != 0);
      exp_sr = !exp_mv;
      if (exp_mv && mr && q[0].last) exp_sr = 1'b1;
      if (!rst) begin
         chk("mValid", 32'(mValid), 32'(exp_mv));
         chk("busy", 32'(busy), 32'(exp_mv));
         if (exp_mv) begin
            chk("out_bits", 32'(out_bits), 32'(q[0].bits));
            chk("out_len", 32'(out_len), 32'(q[0].len));
         end else begin
            chk("idle_bits", 32'(out_bits), 32'd0);
            chk("idle_len", 32'(out_len), 32'd0);
         end
         chk("sReady", 32'(sReady), 32'(exp_sr));
      end
      last_sready = sReady;
      hs_in  = !rst && sv && exp_sr;
      hs_out = !rst && exp_mv && mr;
      ob = out_bits; ol = out_len;
      @(posedge clk);
      #1;
      if (rst) begin
         q.delete(); sent.delete(); decoded.delete();
         rx = ""; bits_model = 0;
      end else begin
         if (hs_out) begin
            void'(q.pop_front());
            bits_model += int'(ol);
            if (bits_model > 2**CNT_W - 1) bits_model = 2**CNT_W - 1;
            for (int j = 0; j < int'(ol); j++) rx = {rx, ob[CHUNK-1-j] ? "1" : "0"};
            decode_rx();
         end
         if (hs_in) begin
            push_code(sd);
            sent.push_back(sd);
         end
      end
      chk("bits_sent", 32'(bits_sent), 32'(bits_model));
      acc = hs_in;
   endtask

   task automatic check_decoded(input string tag);
      chk({tag, "_count"}, 32'(decoded.size()), 32'(sent.size()));
      for (int i = 0; i < sent.size() && i < decoded.size(); i++) begin
         chk({tag, "_sym"}, 32'(decoded[i]), 32'(sent[i]));
      end
   endtask

   initial begin
      bit acc;
      int seq[5];
      int tries;
      total = 0; bad = 0; bits_model = 0; rx = "";
      reset = 1'b1; sValid = 1'b0; symData = '0; mReady = 1'b0;

      // Reset state
      cyc(1, 0, 0, 0, acc);
      cyc(1, 0, 0, 0, acc);
      cyc(0, 0, 0, 0, acc);
      chk("rst_mValid", 32'(mValid), 32'd0);
      chk("rst_len", 32'(out_len), 32'd0);
      chk("rst_bits", 32'(out_bits), 32'd0);
      chk("rst_sReady", 32'(last_sready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);

      // Single short code
      cyc(0, 1, 0, 1, acc);
      chk("short_bits", 32'(out_bits), 32'h0);
      chk("short_len", 32'(out_len), 32'd2);
      chk("short_mValid", 32'(mValid), 32'd1);
      cyc(0, 0, 0, 1, acc);
      chk("short_after", 32'(mValid), 32'd0);
      chk("short_cnt", 32'(bits_sent), 32'd2);

      // Max-length code
      cyc(1, 0, 0, 0, acc);
      cyc(0, 1, -8, 1, acc);
      chk("max_c1", {out_bits, 1'b0, out_len}, {4'hF, 1'b0, 3'd4});
      cyc(0, 0, 0, 1, acc);
      chk("max_c1_sready", 32'(last_sready), 32'd0);
      chk("max_c2", {out_bits, 1'b0, out_len}, {4'h0, 1'b0, 3'd4});
      cyc(0, 0, 0, 1, acc);
      chk("max_c2_sready", 32'(last_sready), 32'd0);
      chk("max_c3", {out_bits, 1'b0, out_len}, {4'h0, 1'b0, 3'd1});
      cyc(0, 0, 0, 1, acc);
      chk("max_c3_sready", 32'(last_sready), 32'd1);
      chk("max_cnt", 32'(bits_sent), 32'd9);

      // Backpressure
      cyc(1, 0, 0, 0, acc);
      cyc(0, 1, 7, 1, acc);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 0, 0, acc);
         chk("bp_hold", {out_bits, 1'b0, out_len}, {4'hE, 1'b0, 3'd4});
         chk("bp_sready", 32'(last_sready), 32'd0);
      end
      cyc(0, 0, 0, 1, acc);
      chk("bp_c2", {out_bits, 1'b0, out_len}, {4'h8, 1'b0, 3'd2});
      cyc(0, 0, 0, 1, acc);
      chk("bp_cnt", 32'(bits_sent), 32'd6);

      // Back-to-back
      cyc(1, 0, 0, 0, acc);
      cyc(0, 1, 1, 1, acc);
      chk("b2b_1", {out_bits, 1'b0, out_len}, {4'h4, 1'b0, 3'd3});
      cyc(0, 1, -1, 1, acc);
      chk("b2b_2", {out_bits, 1'b0, out_len}, {4'h6, 1'b0, 3'd3});
      cyc(0, 1, 2, 1, acc);
      chk("b2b_3", {out_bits, 1'b0, out_len}, {4'h8, 1'b0, 3'd4});
      cyc(0, 0, 0, 1, acc);
      chk("b2b_cnt", 32'(bits_sent), 32'd10);

      // Loopback decode of the emitted stream
      cyc(1, 0, 0, 0, acc);
      seq = '{0, -8, 7, 3, -5};
      foreach (seq[k]) begin
         acc = 1'b0;
         tries = 0;
         while (!acc && tries < 8) begin
            cyc(0, 1, seq[k], 1, acc);
            tries++;
         end
         chk("loop_accept", 32'(acc), 32'd1);
      end
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, acc);
      check_decoded("loop");

      // Mid-code reset
      cyc(1, 0, 0, 0, acc);
      cyc(0, 1, -8, 1, acc);
      cyc(0, 0, 0, 1, acc);
      cyc(1, 0, 0, 1, acc);
      chk("mid_mValid", 32'(mValid), 32'd0);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 0, 1, acc);
         chk("mid_quiet", 32'(mValid), 32'd0);
      end
      chk("mid_cnt", 32'(bits_sent), 32'd0);

      // Random traffic with random backpressure; counter saturates
      cyc(1, 0, 0, 0, acc);
      for (int i = 0; i < 800; i++) begin
         cyc(0, bit'($urandom_range(0, 1)), int'($urandom_range(0, 15)) - 8,
             bit'($urandom_range(0, 3) != 0), acc);
      end
      for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1, acc);
      check_decoded("rand");
      chk("rand_sat", 32'(bits_sent), 32'(2**CNT_W - 1));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/huffman_chunk_encoder.md
Name: huffman_chunk_encoder

Overview:
Transmit-side counterpart of the shift_reg Huffman decoder. Accepts one signed 4-bit symbol per handshake and looks up its prefix-free code (2..9 bits) in the shared table. Emits the code MSB-first as chunks of up to CHUNK bits, in the (bits, len) format the decoder consumes on its in_bits/in_len/sValid inputs. Sits between the symbol source and the decoder input, or the channel feeding it.

Parameters:
MAX_CODE, 9, longest code length in bits; sizes the code buffer
CHUNK, 4, maximum bits per output chunk; width of out_bits
CNT_W, 16, width of the bits_sent statistics counter

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
symData  input  4  signed symbol to encode, range -8..7
sValid  input  1  symData valid
sReady  output  1  encoder accepts symData this cycle when sValid && sReady
out_bits  output  CHUNK  chunk bits, MSB-aligned; valid bits are [CHUNK-1 : CHUNK-out_len]; unused low bits are 0
out_len  output  3  number of valid bits in out_bits, 1..CHUNK when mValid, else 0
mValid  output  1  chunk valid
mReady  input  1  downstream accepts chunk when mValid && mReady; tie to 1 when driving the decoder
busy  output  1  a code is in flight (state EMIT)
bits_sent  output  CNT_W  total code bits accepted downstream; saturates at all-ones

Behaviour:
- Code table, indexed by symbol:
  - 0=00
  - 1=010, -1=011
  - 2=1000, -2=1001, 3=1010, -3=1011
  - 4=11000, -4=11001, 5=11010, -5=11011
  - 6=111000, -6=111001, 7=111010, -7=111011
  - -8=111100000
- Registers: code_buf[MAX_CODE-1:0] (left-aligned code), rem_len[3:0], state, bits_sent.
- States:
  - IDLE: mValid=0, sReady=1. On sValid, load code_buf and rem_len from the table and go to EMIT.
  - EMIT: mValid=1, out_len=min(rem_len,CHUNK), out_bits=top CHUNK bits of code_buf masked to out_len.
    - On mReady: shift code_buf left by out_len and subtract out_len from rem_len.
    - If rem_len<=CHUNK, this is the last chunk: sReady=1 this cycle. A concurrent sValid loads the next code and stays in EMIT with no bubble; otherwise go to IDLE.
- Latency: symbol accepted in cycle N → first chunk has mValid in cycle N+1. Chunks per symbol = ceil(len/CHUNK). Codes are never merged into one chunk.
- Backpressure: while mValid && !mReady, out_bits, out_len, code_buf and rem_len hold stable, and sReady=0.
- Output timing:
  - All outputs except sReady are driven from registers only.
  - sReady = (state==IDLE) || (mValid && mReady && rem_len<=CHUNK).
  - sReady's combinational dependence on mReady is permitted; there is no other in-to-out combinational path.
- bits_sent increments by out_len on every accepted chunk and saturates at 2^CNT_W-1.
- Reset (synchronous, any state including mid-code):
  - state=IDLE, code_buf=0, rem_len=0, bits_sent=0.
  - Outputs: mValid=0, out_bits=0, out_len=0, busy=0.
  - Remaining chunks of the in-flight code are discarded; no partial code is emitted after reset.
  - sReady=1 from the first cycle after reset deasserts.
- symData is sampled only on handshake. Every 4-bit value is a legal symbol, so there are no error states.

Decomposition:
- huffman_pkg holds MAX_CODE, CHUNK, symbol width, and the code/length table as constants plus a lookup function. Both the encoder and shift_reg import it, making it the single source of truth for the code.
- One sub-module: huffman_code_rom (combinational symbol → {code, len}), instantiated once.
- FSM, buffer and counter stay in huffman_chunk_encoder.

Test Plan:
- Reset: hold reset 2 cycles, then release → mValid=0, out_len=0, out_bits=0000, sReady=1, busy=0, bits_sent=0.
- Single short code: symData=0, one-cycle sValid, mReady=1 → next cycle out_bits=0000, out_len=2, mValid=1; following cycle mValid=0; bits_sent=2.
- Max-length code: symData=-8, mReady=1 → three consecutive chunks 1111/4, 0000/4, 0000/1; sReady=1 only on the third chunk cycle; bits_sent=9.
- Backpressure: symData=7, mReady=0 for 3 cycles → 1110/4 held stable with sReady=0; then mReady=1 → 1000/2 next cycle; bits_sent=6.
- Back-to-back: sValid held with 1, -1, 2, mReady=1 → 0100/3, 0110/3, 1000/4 on consecutive cycles, no bubble; bits_sent=10.
- Loopback: encoder driving shift_reg (mReady=1) with the sequence 0, -8, 7, 3, -5 → decoder tvalid pulses with decodedData 0, -8, 7, 3, -5 in order.
- Mid-code reset: accept -8, assert reset in the cycle after the first chunk → mValid=0 next cycle, no 0000/4 or 0000/1 chunks follow, bits_sent=0.
